if_id_stage: RTL and testbench



---
 rtl/if_id_stage_pkg.sv | 32 +++
 rtl/if_id_stage_pc_unit.sv | 54 +++++
 rtl/if_id_stage.sv | 95 +++++++++
 tb/tb_if_id_stage.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/if_id_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage_pkg
//  Description : Shared CPU constants for fetch, decode and the exception
//                unit. Also defines the IF/ID pipeline-register record.
//  Revision    : 1.0  initial release
// ============================================================================
package if_id_stage_pkg;

   // Architectural reset PC and exception entry point.
   localparam logic [31:0] C_RESET_PC   = 32'h0000_3000;
   localparam logic [31:0] C_EXC_VECTOR = 32'h0000_4180;

   // An all-zero word decodes as a NOP, so it doubles as the bubble encoding.
   localparam logic [31:0] C_NOP        = 32'h0000_0000;

   // Contents of the IF/ID pipeline register.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] pc8;
      logic        valid;
      logic        adel;
   } if_id_t;

   // A fetch address is legal only when it is word aligned.
   function automatic logic is_misaligned(input logic [31:0] addr);
      return (addr[1:0] != 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_stage_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage_pc_unit
//  Description : Program counter register and next-PC priority mux
//                (exception > stall > redirect > sequential).
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_stage_pc_unit
   import if_id_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = C_RESET_PC,
   parameter logic [31:0] EXC_VECTOR = C_EXC_VECTOR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        exc_req_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   assign pc_o       = pc_q;
   assign pc_plus4_o = pc_q + 32'd4;

   // Next-PC select; an exception must escape a stall, and a redirect seen
   // during a stall is dropped because ID keeps presenting it until release.
   // A misaligned redirect target is taken as-is; the fault surfaces in ID.
   always_comb begin
      pc_d = pc_plus4_o;
      if (exc_req_i) begin
         pc_d = EXC_VECTOR;
      end else if (stall_i) begin
         pc_d = pc_q;
      end else if (redirect_valid_i) begin
         pc_d = redirect_pc_i;
      end
   end

   // PC register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_stage
//  Description : Instruction-fetch stage plus IF/ID pipeline register.
//                Drives the fetch address and latches the fetched word,
//                its PC and its link address into ID.
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = C_RESET_PC,
   parameter logic [31:0] EXC_VECTOR = C_EXC_VECTOR
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        flush,
   input  logic        exc_req,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr_d,
   output logic [31:0] pc_d,
   output logic [31:0] pc8_d,
   output logic [15:0] imm16_d,
   output logic        valid_d,
   output logic        adel_d
);

   logic [31:0] if_pc;
   logic [31:0] if_pc_plus4;
   logic [31:0] if_pc_plus8;
   if_id_t      if_id_q;
   if_id_t      if_id_d;

   if_id_stage_pc_unit #(
      .RESET_PC   (RESET_PC),
      .EXC_VECTOR (EXC_VECTOR)
   ) u_pc_unit (
      .clk              (clk),
      .reset            (reset),
      .stall_i          (stall),
      .exc_req_i        (exc_req),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .pc_o             (if_pc),
      .pc_plus4_o       (if_pc_plus4)
   );

   assign imem_addr   = if_pc;
   assign if_pc_plus8 = if_pc_plus4 + 32'd4;

   // IF/ID next value: kill beats stall; a misaligned fetch enters ID as a
   // valid NOP tagged with adel so the exception unit can take it there.
   always_comb begin
      if_id_d.instr = imem_rdata;
      if_id_d.pc    = if_pc;
      if_id_d.pc8   = if_pc_plus8;
      if_id_d.valid = 1'b1;
      if_id_d.adel  = 1'b0;
      if (flush || exc_req) begin
         if_id_d.instr = C_NOP;
         if_id_d.valid = 1'b0;
      end else if (stall) begin
         if_id_d = if_id_q;
      end else if (is_misaligned(if_pc)) begin
         if_id_d.instr = C_NOP;
         if_id_d.adel  = 1'b1;
      end
   end

   // IF/ID pipeline register with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         if_id_q.instr <= C_NOP;
         if_id_q.pc    <= 32'd0;
         if_id_q.pc8   <= 32'd8;
         if_id_q.valid <= 1'b0;
         if_id_q.adel  <= 1'b0;
      end else begin
         if_id_q <= if_id_d;
      end
   end

   assign instr_d = if_id_q.instr;
   assign pc_d    = if_id_q.pc;
   assign pc8_d   = if_id_q.pc8;
   assign imm16_d = if_id_q.instr[15:0];
   assign valid_d = if_id_q.valid;
   assign adel_d  = if_id_q.adel;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_id_stage
//  Description : Self-checking bench for if_id_stage: directed scenarios
//                followed by random control traffic, compared every cycle
//                against a behavioural model of the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_if_id_stage;

   localparam logic [31:0] RST_PC = 32'h0000_3000;
   localparam logic [31:0] EXC_PC = 32'h0000_4180;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        exc_req;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_d;
   logic [31:0] pc_d;
   logic [31:0] pc8_d;
   logic [15:0] imm16_d;
   logic        valid_d;
   logic        adel_d;

   int checks   = 0;
   int failures = 0;

   // Model state: what the fetch stage should hold.
   logic [31:0] m_pc;
   logic [31:0] m_instr;
   logic [31:0] m_pcd;
   logic [31:0] m_pc8;
   logic        m_valid;
   logic        m_adel;

   if_id_stage dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .exc_req        (exc_req),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .instr_d        (instr_d),
      .pc_d           (pc_d),
      .pc8_d          (pc8_d),
      .imm16_d        (imm16_d),
      .valid_d        (valid_d),
      .adel_d         (adel_d)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents: a distinct word per address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("imem_addr", imem_addr, m_pc);
      chk("instr_d",   instr_d,   m_instr);
      chk("pc_d",      pc_d,      m_pcd);
      chk("pc8_d",     pc8_d,     m_pc8);
      chk("imm16_d",   {16'h0, imm16_d}, {16'h0, m_instr[15:0]});
      chk("valid_d",   {31'h0, valid_d}, {31'h0, m_valid});
      chk("adel_d",    {31'h0, adel_d},  {31'h0, m_adel});
   endtask

   // Apply one cycle of controls, advance the model with the rules of the
   // fetch stage, then compare after the edge.
   task automatic step(input logic rst, input logic stl, input logic fl,
                       input logic ex, input logic rv, input logic [31:0] rpc);
      logic [31:0] old_pc;
      reset = rst; stall = stl; flush = fl; exc_req = ex;
      redirect_valid = rv; redirect_pc = rpc;
      @(posedge clk);
      old_pc = m_pc;
      if (rst) begin
         m_pc = RST_PC; m_instr = 0; m_pcd = 0; m_pc8 = 8; m_valid = 0; m_adel = 0;
      end else begin
         if (fl || ex) begin
            m_instr = 0; m_valid = 0; m_adel = 0; m_pcd = old_pc; m_pc8 = old_pc + 8;
         end else if (!stl) begin
            m_valid = 1;
            m_pcd   = old_pc;
            m_pc8   = old_pc + 8;
            m_adel  = (old_pc % 4) != 0;
            m_instr = m_adel ? 32'h0 : mem_word(old_pc);
         end
         if (ex)       m_pc = EXC_PC;
         else if (stl) m_pc = old_pc;
         else if (rv)  m_pc = rpc;
         else          m_pc = old_pc + 4;
      end
      #1;
      check_all();
   endtask

   initial begin
      reset = 1; stall = 0; flush = 0; exc_req = 0; redirect_valid = 0; redirect_pc = 0;
      m_pc = 0; m_instr = 0; m_pcd = 0; m_pc8 = 0; m_valid = 0; m_adel = 0;

      // Reset state.
      step(1, 0, 0, 0, 0, 0);
      chk("rst_addr", imem_addr, 32'h3000);
      chk("rst_pc8", pc8_d, 32'd8);

      // Free-running fetch.
      step(0, 0, 0, 0, 0, 0);
      chk("seq_addr1", imem_addr, 32'h3004);
      chk("seq_pc8", pc8_d, 32'h3008);
      step(0, 0, 0, 0, 0, 0);
      chk("seq_addr2", imem_addr, 32'h3008);

      // Branch in ID while delay slot 0x3008 is fetched.
      step(0, 0, 0, 0, 1, 32'h3100);
      chk("ds_pc", pc_d, 32'h3008);
      chk("ds_valid", {31'h0, valid_d}, 32'd1);
      chk("br_addr", imem_addr, 32'h3100);

      // Stall two cycles with a pending redirect, then release.
      step(0, 1, 0, 0, 1, 32'h3200);
      step(0, 1, 0, 0, 1, 32'h3200);
      chk("stall_addr", imem_addr, 32'h3100);
      step(0, 0, 0, 0, 1, 32'h3200);
      chk("release_addr", imem_addr, 32'h3200);

      // Exception during stall.
      step(0, 1, 0, 1, 0, 0);
      chk("exc_addr", imem_addr, 32'h4180);
      chk("exc_instr", instr_d, 32'h0);

      // Misaligned redirect target.
      step(0, 0, 0, 0, 1, 32'h3102);
      step(0, 0, 0, 0, 0, 0);
      chk("adel_flag", {31'h0, adel_d}, 32'd1);
      chk("adel_pc", pc_d, 32'h3102);

      // Flush with stall, then reset mid-stall.
      step(0, 1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 1, 32'h5000);
      step(1, 1, 0, 0, 1, 32'h5000);
      chk("midrst_addr", imem_addr, 32'h3000);

      // Random control traffic.
      for (int i = 0; i < 400; i++) begin
         logic [31:0] rpc;
         rpc = $urandom;
         if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
         step($urandom_range(0, 49) == 0,
              $urandom_range(0, 4) == 0,
              $urandom_range(0, 9) == 0,
              $urandom_range(0, 19) == 0,
              $urandom_range(0, 3) == 0,
              rpc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
